// File: rtl/data_mem_ctrl_pkg.sv
// ---------------------------------------------------------------
// mips_pkg : shared FSM state encoding and default data width
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package mips_pkg;
   localparam int DATA_WIDTH_DEF = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;
endpackage

`default_nettype wire

// File: rtl/data_mem_ctrl_if.sv
// ---------------------------------------------------------------
// data_mem_ctrl_if : core-side request and memory-side bus bundle
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

interface data_mem_ctrl_if
   import mips_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
   logic                  MemRead;
   logic                  MemWrite;
   logic [DATA_WIDTH-1:0] ALUResult;
   logic [DATA_WIDTH-1:0] WD;
   logic [DATA_WIDTH-1:0] RD;
   logic                  stall;
   logic                  mem_err;
   logic                  mem_req;
   logic                  mem_we;
   logic [DATA_WIDTH-3:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic                  mem_ready;

   modport slave (
      input  MemRead, MemWrite, ALUResult, WD, mem_rdata, mem_ready,
      output RD, stall, mem_err, mem_req, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output MemRead, MemWrite, ALUResult, WD, mem_rdata, mem_ready,
      input  RD, stall, mem_err, mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

`default_nettype wire

// File: rtl/data_mem_ctrl_timeout_counter.sv
// ---------------------------------------------------------------
// timeout_counter : counts unanswered ACCESS cycles, flags limit
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module timeout_counter #(
   parameter int TIMEOUT = 16
) (
   input  wire logic clk,
   input  wire logic rst,
   input  wire logic clr,
   input  wire logic en,
   output logic      expired
);
   localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

   logic [7:0] cnt_q;
   logic [7:0] cnt_d;

   assign expired = (cnt_q == LIMIT);

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (en && !expired)
         cnt_d = cnt_q + 8'd1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end
endmodule

`default_nettype wire

// File: rtl/data_mem_ctrl.sv
// ---------------------------------------------------------------
// data_mem_ctrl : single-outstanding data-memory access controller
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module data_mem_ctrl
   import mips_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int TIMEOUT    = 16
) (
   input  wire logic      clk,
   input  wire logic      rst,
   data_mem_ctrl_if.slave bus
);
   state_t                state_q, state_d;
   logic [DATA_WIDTH-3:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0] rd_q, rd_d;
   logic                  we_q, we_d;
   logic                  err_q, err_d;
   logic                  stall_w;
   logic                  req_w;
   logic                  tmo_expired;

   timeout_counter #(.TIMEOUT(TIMEOUT)) u_tmo (
      .clk     (clk),
      .rst     (rst),
      .clr     (state_q != ACCESS),
      .en      ((state_q == ACCESS) && !bus.mem_ready),
      .expired (tmo_expired)
   );

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rd_d    = rd_q;
      we_d    = we_q;
      err_d   = err_q;
      stall_w = 1'b0;
      req_w   = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.MemRead || bus.MemWrite) begin
               stall_w = 1'b1;
               if ((bus.MemRead ^ bus.MemWrite) && (bus.ALUResult[1:0] == 2'b00)) begin
                  addr_d  = bus.ALUResult[DATA_WIDTH-1:2];
                  wdata_d = bus.WD;
                  we_d    = bus.MemWrite;
                  state_d = ACCESS;
               end else begin
                  err_d   = 1'b1;
                  state_d = DONE;
               end
            end
         end
         ACCESS: begin
            stall_w = 1'b1;
            req_w   = 1'b1;
            // A response on the limit cycle wins over the timeout
            if (bus.mem_ready) begin
               if (!we_q)
                  rd_d = bus.mem_rdata;
               state_d = DONE;
            end else if (tmo_expired) begin
               if (!we_q)
                  rd_d = '0;
               err_d   = 1'b1;
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         rd_q    <= '0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rd_q    <= rd_d;
         we_q    <= we_d;
         err_q   <= err_d;
      end
   end

   assign bus.RD        = rd_q;
   assign bus.stall     = stall_w;
   assign bus.mem_err   = err_q;
   assign bus.mem_req   = req_w;
   assign bus.mem_we    = we_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
endmodule

`default_nettype wire
